// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, default
// PC bounds and the instruction word width.
package pc_fetch_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_LIMIT = 32'd1020;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_KILL = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch.sv
// Single-outstanding instruction fetch: owns the PC, issues one memory request
// at a time, holds the returned word for decode and squashes on redirect.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] PC_LIMIT = DEF_PC_LIMIT
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        pc_out,
  input  logic [31:0]        npc_in,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_addr,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [31:0]        instr_pc
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc_nxt;
  logic         capture;
  logic         stale;
  logic         rvalid_eff;

  function automatic logic [31:0] pick_pc(input logic        use_redirect,
                                          input logic [31:0] target,
                                          input logic [31:0] seq);
    logic [31:0] cand;
    cand = use_redirect ? (target & ~32'h3) : seq;
    return (cand > PC_LIMIT) ? RESET_PC : cand;
  endfunction

  // A response still in flight when reset hit in WAIT belongs to nobody.
  assign rvalid_eff = imem_rvalid && !stale;
  assign imem_addr  = pc_out & ~32'h3;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_out;
    capture     = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      ST_REQ: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          pc_nxt    = pick_pc(1'b1, redirect_addr, npc_in);
          state_nxt = imem_gnt ? ST_KILL : ST_REQ;
        end else if (imem_gnt) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_nxt    = pick_pc(1'b1, redirect_addr, npc_in);
          state_nxt = rvalid_eff ? ST_REQ : ST_KILL;
        end else if (rvalid_eff) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        instr_valid = 1'b1;
        if (redirect_valid) begin
          pc_nxt    = pick_pc(1'b1, redirect_addr, npc_in);
          state_nxt = ST_REQ;
        end else if (instr_ready) begin
          pc_nxt    = pick_pc(1'b0, redirect_addr, npc_in);
          state_nxt = ST_REQ;
        end
      end
      ST_KILL: begin
        if (redirect_valid) begin
          pc_nxt = pick_pc(1'b1, redirect_addr, npc_in);
        end
        if (rvalid_eff) begin
          state_nxt = ST_REQ;
        end
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_REQ;
      pc_out     <= RESET_PC;
      instr_data <= '0;
      instr_pc   <= '0;
    end else begin
      state  <= state_nxt;
      pc_out <= pc_nxt;
      if (capture) begin
        instr_data <= imem_rdata;
        instr_pc   <= pc_out;
      end
    end
  end

  // Flag survives a multi-cycle reset and is consumed by the first rvalid seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      stale <= (state == ST_WAIT || stale) && !imem_rvalid;
    end else begin
      stale <= stale && !imem_rvalid;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bench for pc_fetch with a transaction-level reference model and
// directed scenarios pinning latency, wrap, hold, redirect and reset behaviour.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_out, npc_in;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;

  pc_fetch #(.RESET_PC(32'h0000_0000), .PC_LIMIT(32'd1020)) dut (
    .clk(clk), .reset(reset), .pc_out(pc_out), .npc_in(npc_in),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;
  assign npc_in = pc_out + 32'd4;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // reference model: outstanding-transaction view of the fetch unit
  logic        armed = 1'b0;
  logic [31:0] m_pc = '0, m_data = '0, m_ipc = '0;
  logic        m_out = 1'b0, m_squash = 1'b0, m_hold = 1'b0, m_stale = 1'b0;

  // memory + stimulus knobs
  int unsigned gnt_pct, rdy_pct, redir_pct, rst_permil, dly_min, dly_max;
  int unsigned rst_cnt = 0;
  int unsigned cnt = 0;
  logic        busy = 1'b0, just_granted = 1'b0;
  logic [31:0] g_addr = '0, pend_addr = '0;

  logic [31:0] acc_pc[$];
  logic [31:0] acc_dat[$];
  int          acc_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h2001_0005;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] legal(input logic [31:0] a);
    return (a > 32'd1020) ? 32'd0 : a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_update();
    logic        eff;
    logic [31:0] tgt;
    if (reset) begin
      m_stale  = !imem_rvalid && (m_stale || (m_out && !m_squash));
      m_pc     = 32'd0;
      m_out    = 1'b0;
      m_squash = 1'b0;
      m_hold   = 1'b0;
      m_data   = 32'd0;
      m_ipc    = 32'd0;
      armed    = 1'b1;
    end else begin
      eff = imem_rvalid && !m_stale;
      if (imem_rvalid) m_stale = 1'b0;
      tgt = redirect_valid ? legal(redirect_addr & ~32'h3) : legal(m_pc + 32'd4);
      if (m_hold) begin
        if (redirect_valid || instr_ready) begin
          m_hold = 1'b0;
          m_pc   = tgt;
        end
      end else if (m_out) begin
        if (eff) begin
          if (!m_squash && !redirect_valid) begin
            m_hold = 1'b1;
            m_data = imem_rdata;
            m_ipc  = m_pc;
          end
          m_out    = 1'b0;
          m_squash = 1'b0;
        end
        if (redirect_valid) begin
          m_pc = tgt;
          if (m_out) m_squash = 1'b1;
        end
      end else begin
        if (redirect_valid) m_pc = tgt;
        if (imem_gnt) begin
          m_out    = 1'b1;
          m_squash = redirect_valid;
        end
      end
    end
  endtask

  // advance one clock, update the model from the inputs seen at the edge, then drive new inputs
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_update();
    just_granted = imem_gnt;
    if (imem_rvalid) busy = 1'b0;
    if (imem_gnt) begin
      busy      = 1'b1;
      cnt       = $urandom_range(dly_max, dly_min);
      pend_addr = g_addr;
    end
    reset = (rst_cnt > 0) || ($urandom_range(999, 0) < rst_permil);
    if (rst_cnt > 0) rst_cnt--;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (busy) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
      end
    end else if (!reset && imem_req && $urandom_range(99, 0) < gnt_pct) begin
      imem_gnt = 1'b1;
      g_addr   = imem_addr;
    end
    instr_ready    = $urandom_range(99, 0) < rdy_pct;
    redirect_valid = $urandom_range(99, 0) < redir_pct;
    redirect_addr  = ($urandom_range(3, 0) == 0) ? 32'd1012 + $urandom_range(15, 0)
                                                 : 32'($urandom_range(1100, 0));
  endtask

  task automatic clear_acc();
    acc_pc.delete();
    acc_dat.delete();
    acc_cyc.delete();
  endtask

  task automatic wait_acc(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (acc_pc.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (acc_pc.size() < n) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, got %0d accepted expected %0d", nm, acc_pc.size(), n);
    end
  endtask

  task automatic wait_grant(input string nm);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!just_granted && k < 30);
    if (!just_granted) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout waiting for grant, got 0 expected 1", nm);
    end
  endtask

  // compare process: every cycle after the first reset
  always @(negedge clk) begin
    if (armed) begin
      chk("pc_out", pc_out, m_pc);
      chk("imem_req", 32'(imem_req), 32'(!m_out && !m_hold));
      if (!m_out && !m_hold) chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(m_hold));
      chk("instr_data", instr_data, m_data);
      chk("instr_pc", instr_pc, m_ipc);
      if (instr_valid && instr_ready && !redirect_valid && !reset) begin
        acc_pc.push_back(instr_pc);
        acc_dat.push_back(instr_data);
        acc_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_seq[4];
    logic        found;
    int          k;

    reset = 1'b1; redirect_valid = 1'b0; redirect_addr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    gnt_pct = 100; rdy_pct = 100; redir_pct = 0; rst_permil = 0;
    dly_min = 1; dly_max = 1; rst_cnt = 2;

    // reset, immediate grant, rvalid +1, ready tied high
    repeat (3) tick();
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_valid", 32'(instr_valid), 32'h0);
    chk("reset_req", 32'(imem_req), 32'h1);
    clear_acc();
    wait_acc(4, 40, "seq_timeout");
    exp_seq = '{32'd0, 32'd4, 32'd8, 32'd12};
    for (int i = 0; i < 4; i++) chk("seq_pc", acc_pc[i], exp_seq[i]);
    for (int i = 1; i < 4; i++) chk("seq_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);

    // run off the end of the legal range
    tick();
    redirect_valid = 1'b1; redirect_addr = 32'd1016;
    clear_acc();
    wait_acc(4, 40, "wrap_timeout");
    exp_seq = '{32'd1016, 32'd1020, 32'd0, 32'd4};
    for (int i = 0; i < 4; i++) chk("wrap_pc", acc_pc[i], exp_seq[i]);

    // decode stalls with a word held at 0x10 (unaligned redirect 0x12)
    rdy_pct = 0;
    tick();
    redirect_valid = 1'b1; redirect_addr = 32'h12;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = instr_valid && instr_pc == 32'h10;
    end
    chk("hold_reached", 32'(found), 32'h1);
    repeat (5) begin
      tick();
      chk("hold_valid", 32'(instr_valid), 32'h1);
      chk("hold_data", instr_data, 32'h2001_0005);
      chk("hold_pc", instr_pc, 32'h10);
      chk("hold_noreq", 32'(imem_req), 32'h0);
    end
    rdy_pct = 100;

    // redirect while a response is pending
    dly_min = 3; dly_max = 3;
    wait_grant("wait_redirect");
    redirect_valid = 1'b1; redirect_addr = 32'h43;
    clear_acc();
    tick();
    chk("kill_noreq", 32'(imem_req), 32'h0);
    chk("kill_novalid", 32'(instr_valid), 32'h0);
    k = 0;
    while (!imem_req && k < 12) begin
      tick();
      k++;
    end
    chk("redir_req", 32'(imem_req), 32'h1);
    chk("redir_addr", imem_addr, 32'h40);
    wait_acc(1, 30, "redir_timeout");
    chk("redir_pc", acc_pc[0], 32'h40);
    chk("redir_data", acc_dat[0], mem_word(32'h40));

    // redirect beats instr_ready in HOLD
    dly_min = 1; dly_max = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = instr_valid;
    end
    chk("hold2_reached", 32'(found), 32'h1);
    redirect_valid = 1'b1; redirect_addr = 32'h80; instr_ready = 1'b1;
    clear_acc();
    tick();
    chk("drop_valid", 32'(instr_valid), 32'h0);
    wait_acc(1, 30, "drop_timeout");
    chk("drop_next_pc", acc_pc[0], 32'h80);

    // reset during WAIT, the old response shows up afterwards
    dly_min = 3; dly_max = 3;
    wait_grant("rst_wait");
    reset = 1'b1;
    clear_acc();
    wait_acc(1, 40, "rst_timeout");
    chk("rst_first_pc", acc_pc[0], 32'h0);
    chk("rst_first_data", acc_dat[0], mem_word(32'h0));

    // randomized traffic against the model
    gnt_pct = 60; rdy_pct = 70; redir_pct = 8; rst_permil = 10;
    dly_min = 1; dly_max = 3;
    repeat (3000) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000: PC value loaded on reset and used on out-of-range wrap.
REQ-002 Parameter PC_LIMIT, 32'd1020: highest legal fetch byte address; any candidate PC above it is replaced by RESET_PC.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 pc_out  out  32  current PC; drives the next-PC adder input.
REQ-006 npc_in  in  32  sequential next PC from the next-PC adder (combinational function of pc_out).
REQ-007 redirect_valid  in  1  branch/jump redirect strobe, single cycle.
REQ-008 redirect_addr  in  32  redirect target byte address.
REQ-009 imem_req  out  1  instruction memory request.
REQ-010 imem_addr  out  32  request byte address, bits [1:0] always 0.
REQ-011 imem_gnt  in  1  memory accepted request this cycle.
REQ-012 imem_rvalid  in  1  read data valid; at least one cycle after the grant.
REQ-013 imem_rdata  in  32  instruction word.
REQ-014 instr_valid  out  1  instruction presented to decode.
REQ-015 instr_ready  in  1  decode accepts when high with instr_valid.
REQ-016 instr_data  out  32  fetched instruction.
REQ-017 instr_pc  out  32  byte address of instr_data.

Function
REQ-018 States: REQ (imem_req=1), WAIT (awaiting rvalid), HOLD (instr_valid=1), KILL (awaiting rvalid of a squashed fetch).
REQ-019 REQ: imem_addr=pc_out; imem_gnt -> WAIT; request held stable until granted, except under REQ-025.
REQ-020 WAIT: imem_rvalid -> latch instr_data=imem_rdata and instr_pc=pc_out, then HOLD.
REQ-021 HOLD: instr_valid=1; instr_data/instr_pc stable until accepted; instr_ready -> pc_out<=npc_in (subject to REQ-024), then REQ the next cycle.
REQ-022 Minimum latency: grant cycle N, rvalid cycle N+1, instr_valid cycle N+2; throughput of one instruction per 3 cycles is acceptable.
REQ-023 Redirect targets are word-aligned before use: redirect_addr[1:0] forced to 0.
REQ-024 Candidate PC (npc_in or aligned redirect) > PC_LIMIT -> pc_out loads RESET_PC.
REQ-025 Redirect in REQ without grant: pc_out<=target, stay REQ, imem_addr changes next cycle.
REQ-026 Redirect in REQ with grant same cycle: pc_out<=target, go KILL.
REQ-027 Redirect in WAIT: pc_out<=target, go KILL (or REQ directly if imem_rvalid same cycle; response discarded).
REQ-028 KILL: imem_req=0, instr_valid=0; imem_rvalid discarded, then REQ.
REQ-029 Redirect in HOLD: held instruction dropped (instr_valid low next cycle even if instr_ready this cycle), pc_out<=target, go REQ; redirect has priority over instr_ready.
REQ-030 A redirect during KILL overwrites pc_out; KILL still awaits the outstanding rvalid.
REQ-031 At most one memory transaction outstanding; imem_req never asserted in WAIT, KILL or HOLD.
REQ-032 imem_rvalid outside WAIT/KILL is ignored.

Reset
REQ-033 reset sampled high: next edge pc_out=RESET_PC, state=REQ, instr_valid=0, instr_data=0, instr_pc=0; imem_req=1 from the first cycle after reset release.
REQ-034 reset mid-transaction abandons the outstanding request; one stale rvalid after reset is tolerated and discarded (state counts as KILL-equivalent only if reset asserted in WAIT); reset overrides redirect.

Structure
REQ-035 Shared package holds the fetch state enum, RESET_PC/PC_LIMIT defaults, and the instruction word width constant.
REQ-036 Single module; the candidate-PC select/alignment/limit check is a function, not a sub-module; the next-PC adder stays external.

Verification
REQ-037 Reset, memory grants immediately, rvalid +1, instr_ready tied 1 -> instr_pc sequence 0,4,8,... at one per 3 cycles.
REQ-038 Sequential run to 1020 -> instr_pc 1016,1020 then 0 (npc 1024 > PC_LIMIT wraps to RESET_PC).
REQ-039 Hold instr_ready low 5 cycles with instr 0x2001_0005 at pc 0x10 -> instr_valid, data, pc stable; no imem_req asserted.
REQ-040 Redirect to 0x43 while in WAIT -> pending rvalid data dropped, next imem_addr 0x40, next instr_pc 0x40.
REQ-041 Redirect to 0x80 in HOLD with instr_ready=1 same cycle -> instruction not counted accepted by scoreboard rules, instr_valid 0 next cycle, next fetch at 0x80.
REQ-042 reset asserted in WAIT then stray rvalid -> discarded, first delivered instr_pc = 0.
